mem_access_unit: RTL and testbench



---
 rtl/mem_access_if.sv | 26 ++
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Bundle between the memory-access stage, the pipeline above it and the data RAM.
// master = processor/RAM environment, slave = mem_access_unit.
interface mem_access_if #(
    parameter int ADDR_W = 10
);
    logic [1:0]        MemWrite;
    logic              MemRead;
    logic [31:0]       Addr;
    logic [31:0]       WriteData;
    logic [31:0]       ReadData;
    logic              Stall;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport master (
        output MemWrite, MemRead, Addr, WriteData, ram_rdata,
        input  ReadData, Stall, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  MemWrite, MemRead, Addr, WriteData, ram_rdata,
        output ReadData, Stall, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access stage: word/byte loads and stores against a single-port
// synchronous RAM without byte enables; byte stores are read-modify-write.
module mem_access_unit #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (lane)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  cnt_r;
    logic        op_store_r;
    logic        op_byte_r;
    logic [31:0] read_data_r;
    logic [31:0] merge_r;
    logic        store_req_s;
    logic        load_req_s;
    logic        word_store_s;
    logic        multi_req_s;
    logic        stall_s;
    logic        ram_we_s;
    logic [31:0] ram_wdata_s;
    logic        unused_addr_s;

    // Store has priority over load; MemWrite=2'b10 alone is not a request.
    assign store_req_s   = bus.MemWrite[0];
    assign load_req_s    = ~bus.MemWrite[0] & bus.MemRead;
    assign word_store_s  = store_req_s & ~bus.MemWrite[1];
    assign multi_req_s   = load_req_s | (store_req_s & bus.MemWrite[1]);
    assign unused_addr_s = ^bus.Addr[31:ADDR_W+2];

    assign bus.ram_addr  = bus.Addr[ADDR_W+1:2];
    assign bus.ReadData  = read_data_r;
    assign bus.Stall     = stall_s;
    assign bus.ram_we    = ram_we_s;
    assign bus.ram_wdata = ram_wdata_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (multi_req_s) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r != 2'd0) begin
                    state_nxt_s = S_WAIT;
                end else if (op_store_r) begin
                    state_nxt_s = S_WRITE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            S_WRITE: state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Latency counter, operation latch, load result and byte-merge register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= 2'd0;
            op_store_r  <= 1'b0;
            op_byte_r   <= 1'b0;
            read_data_r <= 32'h0;
            merge_r     <= 32'h0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (multi_req_s) begin
                        cnt_r      <= CNT_INIT;
                        op_store_r <= store_req_s;
                        op_byte_r  <= bus.MemWrite[1];
                    end
                end
                S_WAIT: begin
                    if (cnt_r != 2'd0) begin
                        cnt_r <= cnt_r - 2'd1;
                    end else if (op_store_r) begin
                        merge_r <= lane_put(bus.ram_rdata, bus.Addr[1:0], bus.WriteData[7:0]);
                    end else if (op_byte_r) begin
                        read_data_r <= {24'h0, lane_get(bus.ram_rdata, bus.Addr[1:0])};
                    end else begin
                        read_data_r <= bus.ram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs; held at reset values while reset is asserted so nothing reaches the RAM.
    always_comb begin
        stall_s     = 1'b0;
        ram_we_s    = 1'b0;
        ram_wdata_s = 32'h0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (word_store_s) begin
                        ram_we_s    = 1'b1;
                        ram_wdata_s = bus.WriteData;
                    end else if (multi_req_s) begin
                        stall_s = 1'b1;
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                S_WAIT:  stall_s = 1'b1;
                S_WRITE: begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = merge_r;
                end
                default: stall_s = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: two instances (RD_LAT 1 and 3), each with
// a RAM model, checked against a word-array reference of memory contents.
module tb_mem_access_unit;
    logic        clk;
    logic        reset;
    logic        clr;
    int          sel;
    logic [1:0]  mw;
    logic        mr;
    logic [31:0] addr;
    logic [31:0] wdata;

    int ncmp;
    int nfail;

    mem_access_if #(.ADDR_W(10)) bus1 ();
    mem_access_if #(.ADDR_W(10)) bus3 ();

    mem_access_unit #(.ADDR_W(10), .RD_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_access_unit #(.ADDR_W(10), .RD_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    assign bus1.MemWrite  = (sel == 0) ? mw : 2'b00;
    assign bus1.MemRead   = (sel == 0) ? mr : 1'b0;
    assign bus1.Addr      = addr;
    assign bus1.WriteData = wdata;
    assign bus3.MemWrite  = (sel == 1) ? mw : 2'b00;
    assign bus3.MemRead   = (sel == 1) ? mr : 1'b0;
    assign bus3.Addr      = addr;
    assign bus3.WriteData = wdata;

    logic [31:0] o_rd, o_wdata;
    logic        o_stall, o_we;
    logic [9:0]  o_addr;
    assign o_rd    = (sel == 0) ? bus1.ReadData  : bus3.ReadData;
    assign o_wdata = (sel == 0) ? bus1.ram_wdata : bus3.ram_wdata;
    assign o_stall = (sel == 0) ? bus1.Stall     : bus3.Stall;
    assign o_we    = (sel == 0) ? bus1.ram_we    : bus3.ram_we;
    assign o_addr  = (sel == 0) ? bus1.ram_addr  : bus3.ram_addr;

    // RAM models with 1- and 3-cycle read latency.
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] pipe1 [0:3];
    logic [31:0] pipe3 [0:3];
    int we_cnt1;
    int we_cnt3;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 32'h0;
        end else if (bus1.ram_we) begin
            mem1[bus1.ram_addr] <= bus1.ram_wdata;
        end
        pipe1[0] <= mem1[bus1.ram_addr];
        for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
        if (bus1.ram_we) we_cnt1 <= we_cnt1 + 1;
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int j = 0; j < 1024; j++) mem3[j] <= 32'h0;
        end else if (bus3.ram_we) begin
            mem3[bus3.ram_addr] <= bus3.ram_wdata;
        end
        pipe3[0] <= mem3[bus3.ram_addr];
        for (int j = 1; j < 4; j++) pipe3[j] <= pipe3[j-1];
        if (bus3.ram_we) we_cnt3 <= we_cnt3 + 1;
    end

    assign bus1.ram_rdata = pipe1[0];
    assign bus3.ram_rdata = pipe3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected memory words, last load result, expected write count.
    logic [31:0] refm [0:1][0:1023];
    logic [31:0] last_rd [0:1];
    int          exp_we [0:1];

    function automatic int lat(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic int we_cnt(input int s);
        return (s == 0) ? we_cnt1 : we_cnt3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input int s, input logic [1:0] w, input logic r,
                      input logic [31:0] a, input logic [31:0] d);
        int          n;
        int          idx;
        int          lane;
        logic [31:0] cur;
        logic [31:0] exp_w;
        idx  = int'(a[11:2]);
        lane = int'(a[1:0]);
        cur  = refm[s][idx];
        @(negedge clk);
        sel = s; mw = w; mr = r; addr = a; wdata = d;
        #1;
        chk("ram_addr", {22'h0, o_addr}, {22'h0, a[11:2]});
        if (w == 2'b01) begin
            chk("wstore_we", {31'h0, o_we}, 32'h1);
            chk("wstore_wdata", o_wdata, d);
            chk("wstore_stall", {31'h0, o_stall}, 32'h0);
            refm[s][idx] = d;
            exp_we[s]++;
        end else if (w == 2'b11 || r) begin
            n = 0;
            while (o_stall === 1'b1 && n < 16) begin
                n++;
                @(negedge clk);
                #1;
            end
            chk("stall_len", 32'(n), 32'(lat(s) + 1));
            if (w == 2'b11) begin
                exp_w = (cur & ~(32'hFF << (8 * lane))) | ({24'h0, d[7:0]} << (8 * lane));
                chk("bstore_we", {31'h0, o_we}, 32'h1);
                chk("bstore_wdata", o_wdata, exp_w);
                chk("bstore_rd_kept", o_rd, last_rd[s]);
                refm[s][idx] = exp_w;
                exp_we[s]++;
            end else begin
                exp_w = w[1] ? ((cur >> (8 * lane)) & 32'hFF) : cur;
                chk("load_data", o_rd, exp_w);
                chk("load_we", {31'h0, o_we}, 32'h0);
                last_rd[s] = exp_w;
            end
        end else begin
            chk("idle_we", {31'h0, o_we}, 32'h0);
            chk("idle_stall", {31'h0, o_stall}, 32'h0);
            chk("idle_rd_kept", o_rd, last_rd[s]);
        end
        @(posedge clk);
        #1;
        mw = 2'b00; mr = 1'b0;
        chk("we_count", 32'(we_cnt(s)), 32'(exp_we[s]));
    endtask

    task automatic reset_mid(input int s, input logic [1:0] w, input logic r,
                             input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = s; mw = w; mr = r; addr = a; wdata = d;
        @(negedge clk);
        reset = 1'b1; mw = 2'b00; mr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_rd", o_rd, 32'h0);
        chk("rst_stall", {31'h0, o_stall}, 32'h0);
        chk("rst_we", {31'h0, o_we}, 32'h0);
        chk("rst_no_write", 32'(we_cnt(s)), 32'(exp_we[s]));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          s;
        int          kind;
        logic [1:0]  w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        ncmp = 0; nfail = 0;
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 1024; m++) refm[k][m] = 32'h0;
            last_rd[k] = 32'h0;
            exp_we[k]  = 0;
        end
        sel = 0; mw = 2'b00; mr = 1'b0; addr = 32'h0; wdata = 32'h0;
        reset = 1'b1; clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; clr = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k;
            #1;
            chk("init_rd", o_rd, 32'h0);
            chk("init_stall", {31'h0, o_stall}, 32'h0);
            chk("init_we", {31'h0, o_we}, 32'h0);
            chk("init_wdata", o_wdata, 32'h0);
        end

        // Directed sequence on the RD_LAT=1 instance.
        op(0, 2'b01, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        op(0, 2'b00, 1'b1, 32'h0000_0010, 32'h0);
        op(0, 2'b11, 1'b0, 32'h0000_0012, 32'h0000_00AA);
        op(0, 2'b10, 1'b1, 32'h0000_0013, 32'h0);
        op(0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
        op(0, 2'b01, 1'b1, 32'h0000_0020, 32'h1234_5678);
        op(0, 2'b10, 1'b0, 32'h0000_0024, 32'h5555_5555);
        op(0, 2'b00, 1'b1, 32'hFFFF_F020, 32'h0);

        // Directed sequence on the RD_LAT=3 instance.
        op(1, 2'b01, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        op(1, 2'b00, 1'b1, 32'h0000_0010, 32'h0);
        op(1, 2'b11, 1'b1, 32'h0000_0011, 32'h0000_0077);
        op(1, 2'b10, 1'b1, 32'h0000_0011, 32'h0);

        // Reset during WAIT of a load and of a byte store, then confirm memory untouched.
        reset_mid(1, 2'b00, 1'b1, 32'h0000_0010, 32'h0);
        reset_mid(0, 2'b11, 1'b0, 32'h0000_0010, 32'h0000_00CC);
        op(0, 2'b00, 1'b1, 32'h0000_0010, 32'h0);
        op(1, 2'b00, 1'b1, 32'h0000_0010, 32'h0);

        // Randomized traffic over a small word window with random ignored address bits.
        repeat (300) begin
            s    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 6));
            a    = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            d    = $urandom();
            case (kind)
                0:       begin w = 2'b01; r = 1'b0; end
                1:       begin w = 2'b11; r = 1'b0; end
                2:       begin w = 2'b00; r = 1'b1; end
                3:       begin w = 2'b10; r = 1'b1; end
                4:       begin w = 2'b10; r = 1'b0; end
                5:       begin w = 2'b01; r = 1'b1; end
                default: begin w = 2'b11; r = 1'b1; end
            endcase
            op(s, w, r, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
